// File: rtl/osd_cmd_pkg.sv
// Shared OSD command types: entry layout, command codes, sequencer states, payload decode.
// Latency: n/a (types and a pure combinational helper function).
// Backpressure: n/a.
package osd_cmd_pkg;

  localparam int WIDTH       = 32;
  localparam int BASE_ADDR_W = 16;

  localparam logic [1:0] CMD_DEC = 2'd0;
  localparam logic [1:0] CMD_HEX = 2'd1;
  localparam logic [1:0] CMD_BIN = 2'd2;
  localparam logic [1:0] CMD_RAW = 2'd3;

  typedef struct packed {
    logic [1:0]             osd_cmd_type;
    logic [BASE_ADDR_W-1:0] base_addr;
    logic [WIDTH-1:0]       payload;
    logic                   pending;
  } osd_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_PREP  = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [3:0] dec_digit;
    logic [3:0] hex_digit;
    logic       bin_digit;
    logic [7:0] glyph;
  } osd_fields_t;

  // Least-significant digit of the payload in each radix plus the ASCII glyph
  // the dispatcher draws for this command type.
  function automatic osd_fields_t osd_cmd_decode(input osd_cmd_t c);
    osd_fields_t f;
    f.dec_digit = 4'(c.payload % 32'd10);
    f.hex_digit = c.payload[3:0];
    f.bin_digit = c.payload[0];
    case (c.osd_cmd_type)
      CMD_DEC: f.glyph = 8'h30 + {4'd0, f.dec_digit};
      CMD_HEX: f.glyph = (f.hex_digit < 4'd10) ? (8'h30 + {4'd0, f.hex_digit})
                                               : (8'h37 + {4'd0, f.hex_digit});
      CMD_BIN: f.glyph = 8'h30 + {7'd0, f.bin_digit};
      CMD_RAW: f.glyph = c.payload[7:0];
      default: f.glyph = 8'h00;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/osd_seq_rr_arbiter.sv
// Round-robin pick of the first requesting bank at or after rr_ptr.
// Latency: combinational.
// Backpressure: none; grant is only a suggestion consumed by the sequencer when idle.
module osd_seq_rr_arbiter #(
  parameter int N_SEQ = 4,
  localparam int SW   = (N_SEQ > 1) ? $clog2(N_SEQ) : 1
) (
  input  logic [N_SEQ-1:0] req,
  input  logic [SW-1:0]    rr_ptr,
  output logic             grant_valid,
  output logic [SW-1:0]    grant_idx
);

  logic [2*N_SEQ-1:0] req_dbl;
  logic [N_SEQ-1:0]   req_rot;
  logic [SW:0]        sum;

  assign req_dbl = {req, req};
  assign req_rot = req_dbl[rr_ptr +: N_SEQ];

  // Scan requests rotated so bit 0 is rr_ptr; map the winner back to a bank number.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int j = 0; j < N_SEQ; j++) begin
      if (!grant_valid && req_rot[j]) begin
        grant_valid = 1'b1;
        sum         = {1'b0, rr_ptr} + (SW+1)'(j);
        grant_idx   = (sum >= (SW+1)'(N_SEQ)) ? SW'(sum - (SW+1)'(N_SEQ)) : SW'(sum);
      end
    end
  end

endmodule

// File: rtl/osd_cmd_multi_seq_enqueuer.sv
// Banked OSD command sequencer: round-robin among started banks, streams pending entries out.
// Latency: start -> first cmd_valid 3 clocks; skipped entry 2 clocks; accept -> next valid 2 clocks.
// Backpressure: cmd_valid/cmd_data held while !cmd_ready. OSD_BATCH_REPEAT_EN adds repeat_en re-arm.
module osd_cmd_multi_seq_enqueuer
  import osd_cmd_pkg::*;
#(
  parameter int N_SEQ         = 4,
  parameter int DEPTH_PER_SEQ = 32,
  localparam int SW = (N_SEQ > 1) ? $clog2(N_SEQ) : 1,
  localparam int AW = $clog2(DEPTH_PER_SEQ),
  localparam int CW = $clog2(DEPTH_PER_SEQ + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [SW-1:0]     load_seq,
  input  logic [AW-1:0]     load_addr,
  input  osd_cmd_t          load_data,
  input  logic [N_SEQ*CW-1:0] seq_count,
  input  logic [N_SEQ-1:0]  start,
`ifdef OSD_BATCH_REPEAT_EN
  input  logic [N_SEQ-1:0]  repeat_en,
`endif
  input  logic              abort,
  output logic              busy,
  output logic [SW-1:0]     active_seq,
  output logic [N_SEQ-1:0]  done,
  output logic              aborted,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [SW-1:0]     cmd_seq,
  output osd_cmd_t          cmd_data
);

  localparam int RAM_N = 1 << (SW + AW);

  seq_state_t       state_q, state_d;
  logic [N_SEQ-1:0] req_q, req_d;
  logic [SW-1:0]    rr_q, rr_d;
  logic             busy_q, busy_d;
  logic [SW-1:0]    act_q, act_d;
  logic [N_SEQ-1:0] done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             vld_q, vld_d;
  logic [SW-1:0]    cseq_q, cseq_d;
  osd_cmd_t         cdat_q, cdat_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             grant_valid;
  logic [SW-1:0]    grant_idx;
  logic [SW-1:0]    rr_next;
  logic [CW-1:0]    sel_cnt;
  logic             rd_en;

  osd_cmd_t         mem [0:RAM_N-1];
  osd_cmd_t         rd_dat_q;

  osd_seq_rr_arbiter #(.N_SEQ(N_SEQ)) u_arb (
    .req         (req_q),
    .rr_ptr      (rr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign rr_next = (grant_idx == SW'(N_SEQ - 1)) ? '0 : grant_idx + SW'(1);

  // Scan length of the bank being granted, clamped so idx never leaves the bank.
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < N_SEQ; i++) begin
      if (grant_idx == SW'(i)) sel_cnt = seq_count[i*CW +: CW];
    end
    if (sel_cnt > CW'(DEPTH_PER_SEQ)) sel_cnt = CW'(DEPTH_PER_SEQ);
  end

  // Command RAM: loader write port plus registered read port; a same-address
  // read in the write cycle returns the previous contents.
  always_ff @(posedge clk) begin
    if (load_we) mem[{load_seq, load_addr}] <= load_data;
    if (rd_en)   rd_dat_q <= mem[{act_q, idx_q[AW-1:0]}];
  end

  // Sequencer next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rr_d      = rr_q;
    busy_d    = busy_q;
    act_d     = act_q;
    done_d    = '0;
    aborted_d = 1'b0;
    vld_d     = vld_q;
    cseq_d    = cseq_q;
    cdat_d    = cdat_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    rd_en     = 1'b0;

    if (abort) begin
      // Abort beats any start or handshake in the same cycle.
      req_d = '0;
      if (state_q != S_IDLE) begin
        state_d   = S_IDLE;
        busy_d    = 1'b0;
        vld_d     = 1'b0;
        aborted_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            req_d[grant_idx] = 1'b0;
            act_d   = grant_idx;
            cnt_d   = sel_cnt;
            idx_d   = '0;
            busy_d  = 1'b1;
            rr_d    = rr_next;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (idx_q >= cnt_q) begin
            state_d = S_DONE;
          end else begin
            rd_en   = 1'b1;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          if (!rd_dat_q.pending) begin
            idx_d   = idx_q + CW'(1);
            state_d = S_FETCH;
          end else begin
            cdat_d  = rd_dat_q;
            cseq_d  = act_q;
            vld_d   = 1'b1;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          if (cmd_ready) begin
            vld_d   = 1'b0;
            idx_d   = idx_q + CW'(1);
            state_d = S_FETCH;
          end
        end
        S_DONE: begin
          done_d[act_q] = 1'b1;
          busy_d        = 1'b0;
          state_d       = S_IDLE;
`ifdef OSD_BATCH_REPEAT_EN
          if (repeat_en[act_q]) req_d[act_q] = 1'b1;
`endif
        end
        default: state_d = S_IDLE;
      endcase
      // Starts are sticky and may re-request the bank just granted or running.
      req_d = req_d | start;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      rr_q      <= '0;
      busy_q    <= 1'b0;
      act_q     <= '0;
      done_q    <= '0;
      aborted_q <= 1'b0;
      vld_q     <= 1'b0;
      cseq_q    <= '0;
      cdat_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rr_q      <= rr_d;
      busy_q    <= busy_d;
      act_q     <= act_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      vld_q     <= vld_d;
      cseq_q    <= cseq_d;
      cdat_q    <= cdat_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

  assign busy       = busy_q;
  assign active_seq = act_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign cmd_valid  = vld_q;
  assign cmd_seq    = cseq_q;
  assign cmd_data   = cdat_q;

endmodule

// File: tb/tb_osd_cmd_multi_seq_enqueuer.sv
// Directed plus randomized bench for the banked OSD command sequencer.
// Latency: n/a.
// Backpressure: cmd_ready driven fixed or random per test.
module tb_osd_cmd_multi_seq_enqueuer;
  import osd_cmd_pkg::*;

  localparam int N  = 4;
  localparam int D  = 32;
  localparam int SW = 2;
  localparam int AW = 5;
  localparam int CW = 6;
  localparam int EW = SW + $bits(osd_cmd_t);

  logic            clk = 1'b0;
  logic            rst;
  logic            load_we;
  logic [SW-1:0]   load_seq;
  logic [AW-1:0]   load_addr;
  osd_cmd_t        load_data;
  logic [N*CW-1:0] seq_count;
  logic [N-1:0]    start;
  logic [N-1:0]    repeat_en;
  logic            abort;
  logic            busy;
  logic [SW-1:0]   active_seq;
  logic [N-1:0]    done;
  logic            aborted;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [SW-1:0]   cmd_seq;
  osd_cmd_t        cmd_data;

  logic rdy_rand = 1'b0;
  logic rdy_man  = 1'b0;
  logic rnd_rdy  = 1'b0;
  assign cmd_ready = rdy_rand ? rnd_rdy : rdy_man;

  always #5 clk = ~clk;

  osd_cmd_multi_seq_enqueuer #(.N_SEQ(N), .DEPTH_PER_SEQ(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_we    (load_we),
    .load_seq   (load_seq),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .seq_count  (seq_count),
    .start      (start),
`ifdef OSD_BATCH_REPEAT_EN
    .repeat_en  (repeat_en),
`endif
    .abort      (abort),
    .busy       (busy),
    .active_seq (active_seq),
    .done       (done),
    .aborted    (aborted),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_seq    (cmd_seq),
    .cmd_data   (cmd_data)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: RAM image, per-bank counts, round-robin pointer, expected streams.
  osd_cmd_t      mdl_mem [N][D];
  int            mdl_cnt [N];
  int            model_rr = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  int            exp_done[$];
  int            obs_done[$];
  int            obs_ab = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  always @(posedge clk) begin
    #2;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor: records transfers, done/aborted pulses, and checks that stalled commands hold.
  logic          stall_p = 1'b0;
  logic [EW-1:0] held_p  = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_p = 1'b0;
    end else begin
      if (stall_p) begin
        chk("hold_valid", 64'(cmd_valid), 64'd1);
        chk("hold_data", 64'({cmd_seq, cmd_data}), 64'(held_p));
      end
      if (cmd_valid && cmd_ready && !abort) obs_q.push_back({cmd_seq, cmd_data});
      for (int b = 0; b < N; b++) if (done[b]) obs_done.push_back(b);
      if (aborted) obs_ab++;
      stall_p = cmd_valid && !cmd_ready && !abort;
      held_p  = {cmd_seq, cmd_data};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_entry(input int b, input int a, input logic pend);
    osd_cmd_t d;
    d.osd_cmd_type = 2'($urandom_range(0, 3));
    d.base_addr    = 16'($urandom);
    d.payload      = $urandom;
    d.pending      = pend;
    load_we   = 1'b1;
    load_seq  = SW'(b);
    load_addr = AW'(a);
    load_data = d;
    tick();
    load_we = 1'b0;
    mdl_mem[b][a] = d;
  endtask

  task automatic set_cnt(input int b, input int v);
    seq_count[b*CW +: CW] = CW'(v);
    mdl_cnt[b] = v;
  endtask

  task automatic pulse_start(input logic [N-1:0] m);
    start = m;
    tick();
    start = '0;
  endtask

  // One bank run: every pending entry below min(count, D), in address order, then done.
  task automatic run_model(input int b);
    int c;
    c = (mdl_cnt[b] > D) ? D : mdl_cnt[b];
    for (int i = 0; i < c; i++)
      if (mdl_mem[b][i].pending) exp_q.push_back({SW'(b), mdl_mem[b][i]});
    exp_done.push_back(b);
    model_rr = (b + 1) % N;
  endtask

  // Banks requested together are served in circular order from the pointer.
  task automatic serve_mask(input logic [N-1:0] mask);
    logic [N-1:0] m;
    int b;
    m = mask;
    for (int n = 0; n < N; n++) begin
      b = -1;
      for (int k = 0; k < N; k++)
        if (b < 0 && m[(model_rr + k) % N]) b = (model_rr + k) % N;
      if (b >= 0) begin
        run_model(b);
        m[b] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    quiet = 0;
    for (int c = 0; c < 4000 && quiet < 6; c++) begin
      tick();
      if (!busy) quiet++;
      else quiet = 0;
    end
    chk({tag, "_idle"}, 64'(quiet >= 6), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!cmd_valid && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_valid_seen"}, 64'(cmd_valid), 64'd1);
  endtask

  task automatic compare_runs(input string tag);
    chk({tag, "_ncmd"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_cmd"}, 64'(obs_q[i]), 64'(exp_q[i]));
    chk({tag, "_ndone"}, 64'(obs_done.size()), 64'(exp_done.size()));
    for (int i = 0; i < exp_done.size() && i < obs_done.size(); i++)
      chk({tag, "_done_bank"}, 64'(obs_done[i]), 64'(exp_done[i]));
    obs_q.delete();
    exp_q.delete();
    obs_done.delete();
    exp_done.delete();
  endtask

  initial begin
    int n;
    logic [N-1:0] mask;

    rst = 1'b1; load_we = 1'b0; load_seq = '0; load_addr = '0; load_data = '0;
    seq_count = '0; start = '0; abort = 1'b0; repeat_en = '0;
    for (int b = 0; b < N; b++) mdl_cnt[b] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_active_seq", 64'(active_seq), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aborted", 64'(aborted), 64'd0);
    chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_seq", 64'(cmd_seq), 64'd0);
    chk("rst_cmd_data", 64'(cmd_data), 64'd0);
    rst = 1'b0;
    tick();

    for (int b = 0; b < N; b++)
      for (int a = 0; a < D; a++) write_entry(b, a, 1'($urandom_range(0, 1)));

    // Bank 0: three pending entries, ready always high, first-command latency.
    for (int a = 0; a < 3; a++) write_entry(0, a, 1'b1);
    set_cnt(0, 3);
    rdy_man = 1'b1;
    pulse_start(4'b0001);
    n = 0;
    while (!cmd_valid && n < 20) begin tick(); n++; end
    chk("A_first_latency", 64'(n), 64'd3);
    serve_mask(4'b0001);
    wait_idle("A");
    compare_runs("A");

    // Bank 1: entries 1 and 3 skipped.
    for (int a = 0; a < 4; a++) write_entry(1, a, (a % 2) == 0);
    set_cnt(1, 4);
    pulse_start(4'b0010);
    serve_mask(4'b0010);
    wait_idle("B");
    compare_runs("B");

    // Bank 3: single command stalled five cycles.
    write_entry(3, 0, 1'b1);
    set_cnt(3, 1);
    rdy_man = 1'b0;
    pulse_start(4'b1000);
    wait_valid("C");
    repeat (5) tick();
    chk("C_stalled_valid", 64'(cmd_valid), 64'd1);
    chk("C_no_transfer_yet", 64'(obs_q.size()), 64'd0);
    rdy_man = 1'b1;
    serve_mask(4'b1000);
    wait_idle("C");
    compare_runs("C");

    // Simultaneous starts 0,1,3 from pointer 0, then bank 0 restarted while 3 runs.
    set_cnt(0, $urandom_range(1, 12));
    set_cnt(1, $urandom_range(1, 12));
    set_cnt(3, $urandom_range(1, 12));
    rdy_rand = 1'b1;
    pulse_start(4'b1011);
    n = 0;
    while (!(busy && active_seq == 2'd3) && n < 3000) begin tick(); n++; end
    chk("D_reached_bank3", 64'(busy && active_seq == 2'd3), 64'd1);
    pulse_start(4'b0001);
    serve_mask(4'b1011);
    serve_mask(4'b0001);
    wait_idle("D");
    compare_runs("D");

    // Abort while the second command of bank 1 is stalled; queued bank 2 is dropped.
    rdy_rand = 1'b0;
    rdy_man  = 1'b0;
    write_entry(1, 0, 1'b1);
    write_entry(1, 1, 1'b1);
    set_cnt(1, 4);
    set_cnt(2, 3);
    pulse_start(4'b0010);
    pulse_start(4'b0100);
    wait_valid("E1");
    rdy_man = 1'b1;
    tick();
    rdy_man = 1'b0;
    wait_valid("E2");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("E_valid_after_abort", 64'(cmd_valid), 64'd0);
    chk("E_busy_after_abort", 64'(busy), 64'd0);
    chk("E_aborted_pulse", 64'(aborted), 64'd1);
    chk("E_no_done", 64'(done), 64'd0);
    tick();
    chk("E_aborted_single", 64'(aborted), 64'd0);
    repeat (8) tick();
    chk("E_queued_cleared", 64'(busy), 64'd0);
    exp_q.push_back({2'd1, mdl_mem[1][0]});
    model_rr = 2;
    compare_runs("E");
    chk("E_abort_count", 64'(obs_ab), 64'd1);

    // Abort together with a start while idle: request dropped, no aborted pulse.
    start = 4'b0100;
    abort = 1'b1;
    tick();
    start = '0;
    abort = 1'b0;
    repeat (6) tick();
    chk("F_idle_abort_busy", 64'(busy), 64'd0);
    chk("F_idle_abort_pulse", 64'(obs_ab), 64'd1);

    // Zero-length bank: done two clocks after grant, no commands.
    set_cnt(2, 0);
    pulse_start(4'b0100);
    n = 0;
    while (!done[2] && n < 20) begin tick(); n++; end
    chk("G_zero_done_latency", 64'(n), 64'd3);
    serve_mask(4'b0100);
    wait_idle("G");
    compare_runs("G");

    // Oversized count is clamped to the whole bank.
    set_cnt(3, D + 1);
    rdy_rand = 1'b1;
    pulse_start(4'b1000);
    serve_mask(4'b1000);
    wait_idle("H");
    compare_runs("H");

    // Random rounds: random entries, counts, masks and backpressure.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++)
        write_entry($urandom_range(0, N-1), $urandom_range(0, D-1), 1'($urandom_range(0, 1)));
      for (int b = 0; b < N; b++) set_cnt(b, $urandom_range(0, D + 1));
      mask = 4'($urandom_range(1, 15));
      pulse_start(mask);
      serve_mask(mask);
      wait_idle("R");
      compare_runs("R");
    end

    // Asynchronous reset while a command is stalled.
    rdy_rand = 1'b0;
    rdy_man  = 1'b0;
    write_entry(0, 0, 1'b1);
    set_cnt(0, 2);
    pulse_start(4'b0001);
    wait_valid("Z");
    #1;
    rst = 1'b1;
    #1;
    chk("Z_async_valid", 64'(cmd_valid), 64'd0);
    chk("Z_async_busy", 64'(busy), 64'd0);
    chk("Z_async_data", 64'(cmd_data), 64'd0);
    chk("Z_async_seq", 64'(cmd_seq), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("Z_no_transfer", 64'(obs_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
